// File: rtl/fp_pkg.sv
// Shared definitions for the FPU sign-injection / min-max unit.
// Covers op encodings, format codes, canonical NaNs and NaN classification helpers.
package fp_pkg;

  localparam logic [2:0] OP_FSGNJ  = 3'b000;
  localparam logic [2:0] OP_FSGNJN = 3'b001;
  localparam logic [2:0] OP_FSGNJX = 3'b010;
  localparam logic [2:0] OP_FMIN   = 3'b100;
  localparam logic [2:0] OP_FMAX   = 3'b101;

  localparam logic FMT_S = 1'b0;
  localparam logic FMT_D = 1'b1;

  localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
  localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

  typedef enum logic [2:0] {
    OPK_SGNJ,
    OPK_SGNJN,
    OPK_SGNJX,
    OPK_MIN,
    OPK_MAX
  } op_kind_e;

  // Unlisted encodings fall back to plain FSGNJ.
  function automatic op_kind_e decode_op(input logic [2:0] op);
    case (op)
      OP_FSGNJN: return OPK_SGNJN;
      OP_FSGNJX: return OPK_SGNJX;
      OP_FMIN:   return OPK_MIN;
      OP_FMAX:   return OPK_MAX;
      default:   return OPK_SGNJ;
    endcase
  endfunction

  function automatic logic is_nan_s(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan_s(input logic [31:0] x);
    return is_nan_s(x) && !x[22];
  endfunction

  function automatic logic is_nan_d(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic is_snan_d(input logic [63:0] x);
    return is_nan_d(x) && !x[51];
  endfunction

endpackage

// File: rtl/fp_sgn_core.sv
// Combinational sign-injection / min-max datapath for S (and D when FLEN=64).
// FP_SGN_NANBOX_EN: S operands must be NaN-boxed and S results are NaN-boxed.
module fp_sgn_core
  import fp_pkg::*;
#(
  parameter int FLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic            fmt_i,
  input  logic [FLEN-1:0] a_i,
  input  logic [FLEN-1:0] b_i,
  output logic [FLEN-1:0] res_o,
  output logic            nv_o
);

`ifdef FP_SGN_NANBOX_EN
  localparam logic NANBOX = (FLEN == 64);
`else
  localparam logic NANBOX = 1'b0;
`endif

  op_kind_e    kind;
  logic        is_d, is_minmax;
  logic [63:0] a64, b64, opa, opb, canon, sj_val, mm_val, res64;
  logic [31:0] a_s, b_s;
  logic        sa, sb, sgn, na, nb, sna, snb, a_lt_b;
  logic [62:0] ma, mb;
  logic        unused_res_hi;

  always_comb begin
    a64 = '0;
    b64 = '0;
    a64[FLEN-1:0] = a_i;
    b64[FLEN-1:0] = b_i;
    is_d = (FLEN == 64) && (fmt_i == FMT_D);
    kind = decode_op(op_i);
    is_minmax = (kind == OPK_MIN) || (kind == OPK_MAX);

    a_s = a64[31:0];
    b_s = b64[31:0];
    // An improperly boxed S operand reads as the canonical quiet NaN.
    if (NANBOX && !is_d) begin
      if (a64[63:32] != 32'hFFFF_FFFF) a_s = CANON_NAN_S;
      if (b64[63:32] != 32'hFFFF_FFFF) b_s = CANON_NAN_S;
    end

    if (is_d) begin
      sa = a64[63];  sb = b64[63];
      ma = a64[62:0]; mb = b64[62:0];
      na = is_nan_d(a64);   nb = is_nan_d(b64);
      sna = is_snan_d(a64); snb = is_snan_d(b64);
      opa = a64; opb = b64;
      canon = CANON_NAN_D;
    end else begin
      sa = a_s[31];  sb = b_s[31];
      ma = {32'd0, a_s[30:0]}; mb = {32'd0, b_s[30:0]};
      na = is_nan_s(a_s);   nb = is_nan_s(b_s);
      sna = is_snan_s(a_s); snb = is_snan_s(b_s);
      opa = {32'd0, a_s}; opb = {32'd0, b_s};
      canon = {32'd0, CANON_NAN_S};
    end

    case (kind)
      OPK_SGNJN: sgn = ~sb;
      OPK_SGNJX: sgn = sa ^ sb;
      default:   sgn = sb;
    endcase
    sj_val = is_d ? {sgn, ma} : {32'd0, sgn, ma[30:0]};

    // Sign-magnitude ordering; -0 sorts below +0 through the sign test.
    if (sa != sb) a_lt_b = sa;
    else if (sa)  a_lt_b = (ma > mb);
    else          a_lt_b = (ma < mb);

    if (na && nb)              mm_val = canon;
    else if (na)               mm_val = opb;
    else if (nb)               mm_val = opa;
    else if (kind == OPK_MIN)  mm_val = a_lt_b ? opa : opb;
    else                       mm_val = a_lt_b ? opb : opa;

    res64 = is_minmax ? mm_val : sj_val;
    if (!is_d) res64[63:32] = NANBOX ? 32'hFFFF_FFFF : 32'h0;

    res_o = res64[FLEN-1:0];
    nv_o  = is_minmax && (sna || snb);
  end

  assign unused_res_hi = ^res64[63:32];

endmodule

// File: rtl/fp_sgn_pipe.sv
// Pipelined FSGNJ/FSGNJN/FSGNJX/FMIN/FMAX unit, STAGES cycles latency, valid/ready with bubble collapse.
// Optional S NaN-boxing via FP_SGN_NANBOX_EN (FLEN=64 only); in_ready depends combinationally on out_ready.
module fp_sgn_pipe
  import fp_pkg::*;
#(
  parameter int FLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_fmt,
  input  logic [FLEN-1:0]  in_a,
  input  logic [FLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLEN-1:0]  out_data,
  output logic             out_nv,
  output logic [TAG_W-1:0] out_tag
);

  logic [FLEN-1:0]  res_d;
  logic             nv_d;
  logic [STAGES-1:0] v_q, v_d, load;
  logic [STAGES-1:0] nv_q;
  logic [FLEN-1:0]  data_q [STAGES];
  logic [TAG_W-1:0] tag_q  [STAGES];

  fp_sgn_core #(.FLEN(FLEN)) u_core (
    .op_i  (in_op),
    .fmt_i (in_fmt),
    .a_i   (in_a),
    .b_i   (in_b),
    .res_o (res_d),
    .nv_o  (nv_d)
  );

  // A stage may load when any stage at or after it is empty or the consumer is taking the head.
  always_comb begin
    logic room;
    room = out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      room    = room | ~v_q[k];
      load[k] = room;
    end
  end

  always_comb begin
    v_d = v_q;
    if (load[0]) v_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) v_d[k] = v_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      nv_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      v_q <= v_d;
      if (load[0] && in_valid) begin
        data_q[0] <= res_d;
        nv_q[0]   <= nv_d;
        tag_q[0]  <= in_tag;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k] && v_q[k-1]) begin
          data_q[k] <= data_q[k-1];
          nv_q[k]   <= nv_q[k-1];
          tag_q[k]  <= tag_q[k-1];
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_nv    = nv_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: doc/fp_sgn_pipe.md
# fp_sgn_pipe

Pipelined sign-injection and min/max unit for the FPU, the parametrised successor to the combinational sign-injection block. Executes FSGNJ/FSGNJN/FSGNJX/FMIN/FMAX on single or double precision operands behind a valid/ready handshake, with configurable pipeline depth. Sits in the FPU execute stage beside the add/mul units and returns results and exception flags, with a tag, to the FPU writeback arbiter.

## Interface
- FLEN, 32: register width; 32 (S only) or 64 (S and D).
- STAGES, 1: pipeline depth, 1..3.
- TAG_W, 5: width of the pass-through tag (destination register index).
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit accepts this cycle.
- in_op  input  3  000 FSGNJ, 001 FSGNJN, 010 FSGNJX, 100 FMIN, 101 FMAX; others treated as FSGNJ.
- in_fmt  input  1  0 = S, 1 = D. Ignored (forced S) when FLEN=32.
- in_a, in_b  input  FLEN  operands.
- in_tag  input  TAG_W  carried unchanged to the output.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- out_data  output  FLEN  result.
- out_nv  output  1  invalid-operation flag; all other flags are always 0.
- out_tag  output  TAG_W  tag of the result.

## Operation
- Field width W = 32 for S, 64 for D. Sign bit is W-1, magnitude is W-2:0.
- FSGNJ: {b.sign, a.mag}. FSGNJN: {~b.sign, a.mag}. FSGNJX: {a.sign^b.sign, a.mag}. Sign-injection never sets nv and never canonicalises NaNs.
- FMIN/FMAX:
  - -0 < +0.
  - One NaN operand: result is the other operand.
  - Both NaN: result is the canonical NaN (S 0x7FC00000, D 0x7FF8000000000000).
  - nv=1 if either operand is a signaling NaN (exponent all ones, mantissa ≠ 0, quiet bit 0), regardless of the result.
- Ordering compare: sign-magnitude. If signs differ, the negative operand is smaller. If both are positive, the larger magnitude is larger. If both are negative, the larger magnitude is smaller.
- S results when FLEN=64: see Configuration.
- All computation happens in stage 0. Stages 1..STAGES-1 are plain register stages.

## Timing
- Latency: exactly STAGES cycles from the accept edge to out_valid, when not stalled.
- Transfer rule: a transfer occurs on a rising edge where valid&&ready. Once out_valid is asserted, out_data, out_nv and out_tag are held stable until accepted.
- Each stage register has its own valid bit v[k]. Stage k loads when !v[k] or stage k+1 takes its contents this cycle (last stage: out_ready). Bubbles collapse.
- in_ready = !v[0] || stage 0 drains this cycle. This is a combinational path from out_ready to in_ready.
- Throughput: one operation per cycle with out_ready held high. A stall never drops or duplicates an operation.
- Simultaneous accept and drain in the same stage: the stage holds the new entry and v stays 1.
- Reset values: all v[k]=0, out_valid=0, out_data=0, out_nv=0, out_tag=0, in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight operations and produces no output transfer.

## Configuration
- FP_SGN_NANBOX_EN applies only when FLEN=64 and fmt=S.
- Defined:
  - An S operand whose bits 63:32 are not all ones is treated as the canonical S NaN.
  - The S result is NaN-boxed: bits 63:32 = 0xFFFFFFFF.
- Undefined:
  - Bits 63:32 of the operands are ignored.
  - Bits 63:32 of the result are 0.
- No effect when FLEN=32.

## Structure
- Package fp_pkg: op encodings, FMT_S/FMT_D, canonical NaN constants, and is_nan/is_snan helper functions.
- Sub-module fp_sgn_core: combinational stage-0 datapath (sign-injection, classify, compare, select, nv), parametrised by FLEN. The top level holds only the handshake and stage registers.

## Test plan
- FLEN=32, STAGES=1, FSGNJN with a=0x3F800000, b=0x3F800000 -> 0xBF800000, nv=0, out_valid one cycle after accept.
- FMIN with a=0x00000000 (+0), b=0x80000000 (-0) -> 0x80000000. FMAX with the same operands -> 0x00000000.
- FMAX with a=0x7F800001 (sNaN), b=0x40000000 -> 0x40000000, nv=1. FMIN with a=0x7FC00001, b=0x7FC00002 -> 0x7FC00000, nv=0.
- FLEN=64, macro defined, S FSGNJ with a=0x000000003F800000 (unboxed), b=0xFFFFFFFF00000000 -> 0xFFFFFFFF7FC00000.
- STAGES=3, stream of 8 operations with out_ready toggling every other cycle:
  - All 8 results and tags arrive in order, with no loss or duplication.
  - Outputs are held stable while stalled.
- rst asserted with 3 operations in flight: next cycle out_valid=0, in_ready=1, and no stale result appears afterwards.
